// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants: active-low glyph patterns (bit0 = a .. bit6 = g) and digit count.
package sevenseg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Inverse hex glyph decoder: active-low segment pattern to nibble, ok=0 for non-glyph patterns.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       ok
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_capture.sv
// Reconstructs the 16-bit hex value from the multiplexed seven-segment bus.
// Optional stale-frame timeout enabled by defining SEVENSEG_CAPTURE_TIMEOUT_EN.
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic [3:0]  value_ok,
    output logic        frame_valid,
    output logic        stale
);

    localparam logic [15:0] STABLE  = 16'(STABLE_CYCLES);
    localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e                  state_q, state_d;
    logic [6:0]              s_seg_q;
    logic [NUM_DIGITS-1:0]   s_an_q;
    logic [15:0]             cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [3:0]              nib_q [NUM_DIGITS];
    logic [3:0]              nib_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   ok_q, ok_d;
    logic [15:0]             value_q, value_d;
    logic [3:0]              value_ok_q;
    logic                    frame_valid_q;

    logic [NUM_DIGITS-1:0]   an_low;
    logic                    slot_valid;
    logic                    pair_same;
    logic                    capture;
    logic                    frame_done;
    logic [3:0]              dec_nibble;
    logic                    dec_ok;

    sevenseg_glyph_decode u_decode (
        .pattern (s_seg_q),
        .nibble  (dec_nibble),
        .ok      (dec_ok)
    );

    // Slot select is only meaningful when exactly one anode is driven low.
    assign an_low     = ~s_an_q;
    assign slot_valid = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    assign pair_same  = ({seg, an} == {s_seg_q, s_an_q});
    assign capture    = pair_same && slot_valid && (cnt_q == STABLE - 16'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (!pair_same || !slot_valid) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_comb begin
        value_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib_d[i] = nib_q[i];
            ok_d[i]  = ok_q[i];
            if (capture && an_low[i]) begin
                nib_d[i] = dec_nibble;
                ok_d[i]  = dec_ok;
            end
            value_d[4*i +: 4] = nib_d[i];
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (capture) state_d = StCollect;
            StCollect: if (frame_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs (frame completion and seen tracking)
    always_comb begin
        frame_done = 1'b0;
        seen_d     = seen_q;
        if (capture) begin
            if ((state_q == StCollect) && ((seen_q | an_low) == '1)) begin
                frame_done = 1'b1;
                seen_d     = '0;
            end else begin
                seen_d = seen_q | an_low;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_seg_q       <= SEG_BLANK;
            s_an_q        <= '1;
            cnt_q         <= '0;
            seen_q        <= '0;
            ok_q          <= '0;
            value_q       <= '0;
            value_ok_q    <= '0;
            frame_valid_q <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_q[i] <= '0;
            end
        end else begin
            s_seg_q       <= seg;
            s_an_q        <= an;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            ok_q          <= ok_d;
            frame_valid_q <= frame_done;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_q[i] <= nib_d[i];
            end
            if (frame_done) begin
                value_q    <= value_d;
                value_ok_q <= ok_d;
            end
        end
    end

    assign value       = value_q;
    assign value_ok    = value_ok_q;
    assign frame_valid = frame_valid_q;

`ifdef SEVENSEG_CAPTURE_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        stale_q;

    assign to_cnt_d = (to_cnt_q == TIMEOUT) ? to_cnt_q : to_cnt_q + 32'd1;

    always_ff @(posedge clk) begin
        if (reset || frame_done) begin
            to_cnt_q <= '0;
            stale_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            stale_q  <= stale_q || (to_cnt_d == TIMEOUT);
        end
    end

    assign stale = stale_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT;
    assign stale              = 1'b0;
`endif

endmodule
